// File: rtl/qproc_time_cmd_arb.sv
// Round-robin arbiter between core and host time-control commands.
// Issues held strobes / run level to the time controller with a fixed hold and gap.
module qproc_time_cmd_arb #(
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 4
) (
  input  logic        c_clk_i,
  input  logic        c_rst_ni,
  input  logic        core_vld_i,
  input  logic [2:0]  core_op_i,
  input  logic [31:0] core_dt_i,
  output logic        core_rdy_o,
  input  logic        host_vld_i,
  input  logic [2:0]  host_op_i,
  input  logic [31:0] host_dt_i,
  output logic        host_rdy_o,
  output logic        c_time_rst_o,
  output logic        c_time_init_o,
  output logic        c_time_updt_o,
  output logic        c_time_en_o,
  output logic [31:0] c_offset_dt_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        last_gnt_o
);

  // state   | meaning
  // S_IDLE  | arbitrating, rdy offered to one requester
  // S_HOLD  | strobe held high, counting HOLD_CYC
  // S_GAP   | all strobes low, counting GAP_CYC
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_RST   = 3'd1;
  localparam logic [2:0] OP_INIT  = 3'd2;
  localparam logic [2:0] OP_UPDT  = 3'd3;
  localparam logic [2:0] OP_START = 3'd4;
  localparam logic [2:0] OP_STOP  = 3'd5;

  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC - 1);
  localparam logic [3:0] GAP_LD  = 4'(GAP_CYC - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_hold_cnt;
  logic [3:0]  r_gap_cnt;
  logic        r_rst;
  logic        r_init;
  logic        r_updt;
  logic        r_en;
  logic [31:0] r_off;
  logic        r_err;
  logic        r_last_gnt;

  logic        w_idle;
  logic        w_sel_core;
  logic        w_sel_host;
  logic        w_acc;
  logic [2:0]  w_op;
  logic [31:0] w_dt;
  logic        w_is_strb;

  assign w_idle     = (r_state == S_IDLE);
  // On a tie the requester that did not win last time gets the grant.
  assign w_sel_core = core_vld_i & (~host_vld_i | r_last_gnt);
  assign w_sel_host = host_vld_i & (~core_vld_i | ~r_last_gnt);
  assign core_rdy_o = c_rst_ni & w_idle & w_sel_core;
  assign host_rdy_o = c_rst_ni & w_idle & w_sel_host;
  assign w_acc      = core_rdy_o | host_rdy_o;
  assign w_op       = host_rdy_o ? host_op_i : core_op_i;
  assign w_dt       = host_rdy_o ? host_dt_i : core_dt_i;
  assign w_is_strb  = (w_op == OP_RST) | (w_op == OP_INIT) | (w_op == OP_UPDT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_acc) w_state_nxt = w_is_strb ? S_HOLD : S_GAP;
      S_HOLD: if (r_hold_cnt == 4'd0) w_state_nxt = S_GAP;
      S_GAP:  if (r_gap_cnt == 4'd0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk_i) begin
    if (!c_rst_ni) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge c_clk_i) begin
    if (!c_rst_ni) begin
      r_hold_cnt <= 4'd0;
      r_gap_cnt  <= 4'd0;
      r_rst      <= 1'b0;
      r_init     <= 1'b0;
      r_updt     <= 1'b0;
      r_en       <= 1'b0;
      r_off      <= 32'd0;
      r_err      <= 1'b0;
      r_last_gnt <= 1'b1;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_last_gnt <= host_rdy_o;
            r_hold_cnt <= HOLD_LD;
            r_gap_cnt  <= GAP_LD;
            case (w_op)
              OP_RST: begin
                r_rst <= 1'b1;
                r_en  <= 1'b0;
              end
              OP_INIT: begin
                r_init <= 1'b1;
                r_off  <= w_dt;
              end
              OP_UPDT: begin
                r_updt <= 1'b1;
                r_off  <= w_dt;
              end
              OP_START: r_en  <= 1'b1;
              OP_STOP:  r_en  <= 1'b0;
              OP_NOP:   r_err <= 1'b0;
              default:  r_err <= 1'b1;
            endcase
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == 4'd0) begin
            r_rst     <= 1'b0;
            r_init    <= 1'b0;
            r_updt    <= 1'b0;
            r_gap_cnt <= GAP_LD;
          end else begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt != 4'd0) r_gap_cnt <= r_gap_cnt - 4'd1;
        end
        default: begin
          r_rst  <= 1'b0;
          r_init <= 1'b0;
          r_updt <= 1'b0;
        end
      endcase
    end
  end

  assign c_time_rst_o  = r_rst;
  assign c_time_init_o = r_init;
  assign c_time_updt_o = r_updt;
  assign c_time_en_o   = r_en;
  assign c_offset_dt_o = r_off;
  assign err_o         = r_err;
  assign last_gnt_o    = r_last_gnt;
  assign busy_o        = ~w_idle;

endmodule

// File: tb/tb_qproc_time_cmd_arb.sv
// Scoreboard bench for qproc_time_cmd_arb: stimulus queues expected command
// responses, a monitor checks each accepted command's full hold/gap window.
module tb_qproc_time_cmd_arb;

  localparam int HOLD = 4;
  localparam int GAP  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_vld = 1'b0, host_vld = 1'b0;
  logic [2:0]  core_op = 3'd0, host_op = 3'd0;
  logic [31:0] core_dt = 32'd0, host_dt = 32'd0;
  logic        core_rdy, host_rdy;
  logic        t_rst, t_init, t_updt, t_en, busy, err, last_gnt;
  logic [31:0] off;

  qproc_time_cmd_arb #(.HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
    .c_clk_i(clk), .c_rst_ni(rst_n),
    .core_vld_i(core_vld), .core_op_i(core_op), .core_dt_i(core_dt), .core_rdy_o(core_rdy),
    .host_vld_i(host_vld), .host_op_i(host_op), .host_dt_i(host_dt), .host_rdy_o(host_rdy),
    .c_time_rst_o(t_rst), .c_time_init_o(t_init), .c_time_updt_o(t_updt),
    .c_time_en_o(t_en), .c_offset_dt_o(off), .busy_o(busy), .err_o(err),
    .last_gnt_o(last_gnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        gnt;
    logic [2:0]  strb;   // {rst, init, updt}
    logic        en;
    logic        err;
    logic [31:0] off;
  } exp_t;

  exp_t        exp_q[$];
  logic [2:0]  cq_op[$], hq_op[$];
  logic [31:0] cq_dt[$], hq_dt[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_busy = 0;

  localparam logic [2:0] S_NONE = 3'b000, S_RST = 3'b100, S_INIT = 3'b010, S_UPDT = 3'b001;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push(input logic g, input logic [2:0] s, input logic e,
                      input logic er, input logic [31:0] o);
    exp_t x;
    x.gnt = g; x.strb = s; x.en = e; x.err = er; x.off = o;
    exp_q.push_back(x);
  endtask

  // Monitor: on each acceptance pop the expected record and check the window.
  initial begin
    bit          have;
    bit          ab;
    exp_t        e;
    logic        g;
    int          ncyc;
    logic [2:0]  s_exp;
    have = 0;
    forever begin
      if (!have) @(negedge clk);
      have = 0;
      if (rst_n && ((core_vld && core_rdy) || (host_vld && host_rdy))) begin
        mon_busy = 1;
        g = host_vld && host_rdy;
        chk("single_rdy", {31'd0, core_rdy & host_rdy}, 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_accept: actual=grant%0d required=none", g);
          e = '0;
        end else begin
          e = exp_q.pop_front();
        end
        chk("grant", {31'd0, g}, {31'd0, e.gnt});
        ncyc = (e.strb != S_NONE) ? HOLD + GAP : GAP;
        ab = 0;
        for (int i = 0; i < ncyc && !ab; i++) begin
          @(negedge clk);
          if (!rst_n) ab = 1;
          else begin
            s_exp = (i < HOLD && e.strb != S_NONE) ? e.strb : S_NONE;
            chk("strobes", {29'd0, t_rst, t_init, t_updt}, {29'd0, s_exp});
            chk("en", {31'd0, t_en}, {31'd0, e.en});
            chk("offset", off, e.off);
            chk("busy_hi", {31'd0, busy}, 32'd1);
            chk("rdy_low", {30'd0, core_rdy, host_rdy}, 32'd0);
            chk("err", {31'd0, err}, (i == 0) ? {31'd0, e.err} : 32'd0);
            if (i == 0) chk("last_gnt", {31'd0, last_gnt}, {31'd0, e.gnt});
          end
        end
        if (!ab) begin
          @(negedge clk);
          if (rst_n) begin
            chk("busy_lo", {31'd0, busy}, 32'd0);
            if (core_vld || host_vld) chk("rdy_back", {31'd0, core_rdy | host_rdy}, 32'd1);
          end
          have = 1;
        end
        mon_busy = 0;
      end
    end
  end

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while ((exp_q.size() != 0 || mon_busy || busy) && cyc < 300);
    if (cyc >= 300) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: actual=busy required=idle");
    end
  endtask

  // Drive both command queues; each side advances after its acceptance.
  task automatic run_traffic();
    int  cyc;
    bit  ac, ah;
    cyc = 0;
    @(posedge clk); #1;
    core_vld = (cq_op.size() != 0);
    if (core_vld) begin core_op = cq_op[0]; core_dt = cq_dt[0]; end
    host_vld = (hq_op.size() != 0);
    if (host_vld) begin host_op = hq_op[0]; host_dt = hq_dt[0]; end
    while ((core_vld || host_vld) && cyc < 500) begin
      @(negedge clk);
      ac = core_vld && core_rdy;
      ah = host_vld && host_rdy;
      @(posedge clk); #1; cyc++;
      if (ac) begin
        void'(cq_op.pop_front()); void'(cq_dt.pop_front());
        core_vld = (cq_op.size() != 0);
        if (core_vld) begin core_op = cq_op[0]; core_dt = cq_dt[0]; end
      end
      if (ah) begin
        void'(hq_op.pop_front()); void'(hq_dt.pop_front());
        host_vld = (hq_op.size() != 0);
        if (host_vld) begin host_op = hq_op[0]; host_dt = hq_dt[0]; end
      end
    end
    if (cyc >= 500) begin
      n_chk++; n_fail++;
      $display("FAIL traffic_timeout: actual=pending required=drained");
      core_vld = 0; host_vld = 0;
    end
    wait_idle();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; core_vld = 1; host_vld = 1; core_op = 3'd4; host_op = 3'd4;
    @(negedge clk);
    chk("rst_rdy", {30'd0, core_rdy, host_rdy}, 32'd0);
    @(posedge clk); #1;
    core_vld = 0; host_vld = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_strobes", {29'd0, t_rst, t_init, t_updt}, 32'd0);
    chk("rst_en", {31'd0, t_en}, 32'd0);
    chk("rst_off", off, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_last_gnt", {31'd0, last_gnt}, 32'd1);
  endtask

  initial begin
    int cyc;
    do_reset();

    // Core UPDT 0x100
    push(0, S_UPDT, 0, 0, 32'h100);
    cq_op.push_back(3'd3); cq_dt.push_back(32'h100);
    run_traffic();

    // Tie after reset: core START wins, host INIT 5 follows at N+5
    do_reset();
    push(0, S_NONE, 1, 0, 32'd0);
    push(1, S_INIT, 1, 0, 32'd5);
    cq_op.push_back(3'd4); cq_dt.push_back(32'd9);
    hq_op.push_back(3'd2); hq_dt.push_back(32'd5);
    run_traffic();

    // Host RST while running
    push(1, S_RST, 0, 0, 32'd5);
    hq_op.push_back(3'd1); hq_dt.push_back(32'd5);
    run_traffic();

    // Core START then illegal op 7, host STOP, core NOP
    push(0, S_NONE, 1, 0, 32'd5);
    push(0, S_NONE, 1, 1, 32'd5);
    cq_op.push_back(3'd4); cq_dt.push_back(32'hDEAD);
    cq_op.push_back(3'd7); cq_dt.push_back(32'hBEEF);
    run_traffic();
    push(1, S_NONE, 0, 0, 32'd5);
    hq_op.push_back(3'd5); hq_dt.push_back(32'h1234);
    run_traffic();
    push(0, S_NONE, 0, 0, 32'd5);
    cq_op.push_back(3'd0); cq_dt.push_back(32'h5678);
    run_traffic();

    // Reset during the 2nd HOLD cycle of a core INIT, host UPDT pending
    push(0, S_INIT, 0, 0, 32'hABCD);
    push(1, S_UPDT, 0, 0, 32'h77);
    @(posedge clk); #1;
    core_vld = 1; core_op = 3'd2; core_dt = 32'hABCD;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!core_rdy && cyc < 50);
    chk("abort_core_rdy", {31'd0, core_rdy}, 32'd1);
    @(posedge clk); #1;
    core_vld = 0; host_vld = 1; host_op = 3'd3; host_dt = 32'h77;
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("abort_init_low", {31'd0, t_init}, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_host_rdy", {30'd0, core_rdy, host_rdy}, 32'd1);
    @(posedge clk); #1;
    host_vld = 0;
    wait_idle();

    // Six back-to-back contended commands: core, host alternating
    push(0, S_UPDT, 0, 0, 32'h11);
    push(1, S_INIT, 0, 0, 32'h33);
    push(0, S_NONE, 1, 0, 32'h33);
    push(1, S_NONE, 1, 0, 32'h33);
    push(0, S_INIT, 1, 0, 32'h22);
    push(1, S_RST, 0, 0, 32'h22);
    cq_op.push_back(3'd3); cq_dt.push_back(32'h11);
    cq_op.push_back(3'd4); cq_dt.push_back(32'h99);
    cq_op.push_back(3'd2); cq_dt.push_back(32'h22);
    hq_op.push_back(3'd2); hq_dt.push_back(32'h33);
    hq_op.push_back(3'd0); hq_dt.push_back(32'h88);
    hq_op.push_back(3'd1); hq_dt.push_back(32'h22);
    run_traffic();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qproc_time_cmd_arb.md
QPROC_TIME_CMD_ARB -- requirements
Module: qproc_time_cmd_arb

Interface
REQ-001 Parameter HOLD_CYC, default 4: cycles each time-control strobe is held high; legal range 2..15.
REQ-002 Parameter GAP_CYC, default 4: cycles all strobes are held low after a hold, before the next command; legal range 2..15.
REQ-003 c_clk_i  in  1  core clock; sole clock of the block.
REQ-004 c_rst_ni  in  1  reset, synchronous, active-low.
REQ-005 core_vld_i / host_vld_i  in  1 each  command request from the core (requester 0) and the host (requester 1).
REQ-006 core_op_i / host_op_i  in  3 each  opcode: 0 NOP, 1 RST, 2 INIT, 3 UPDT, 4 START, 5 STOP, 6-7 illegal.
REQ-007 core_dt_i / host_dt_i  in  32 each  offset / increment operand used by INIT and UPDT.
REQ-008 core_rdy_o / host_rdy_o  out  1 each  command accepted in any cycle where vld and rdy are both high.
REQ-009 c_time_rst_o, c_time_init_o, c_time_updt_o  out  1 each  registered strobes to the time controller.
REQ-010 c_time_en_o  out  1  registered run level to the time controller.
REQ-011 c_offset_dt_o  out  32  registered operand to the time controller.
REQ-012 busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-013 err_o  out  1  one-cycle pulse on acceptance of an illegal opcode.
REQ-014 last_gnt_o  out  1  requester of the most recently accepted command (0 core, 1 host).

Function
REQ-015 FSM states: IDLE, HOLD, GAP; a hold counter and a gap counter, each 4 bits.
REQ-016 In IDLE, rdy is high for exactly one requester: the only requester with vld high, or, when both are valid, the requester other than last_gnt_o (round-robin).
REQ-017 In IDLE with no vld high, both rdy outputs are low.
REQ-018 In HOLD and GAP, both rdy outputs are low; vld may stay high and is not dropped.
REQ-019 On acceptance of RST, INIT or UPDT: in the next cycle, the matching strobe goes high and c_offset_dt_o loads the accepted dt; the FSM enters HOLD.
REQ-020 The strobe stays high for exactly HOLD_CYC cycles, then the FSM enters GAP with all strobes low for exactly GAP_CYC cycles, then returns to IDLE.
REQ-021 At most one of rst/init/updt is high in any cycle.
REQ-022 c_offset_dt_o holds its value from the load cycle through the end of GAP; it changes only on a new INIT or UPDT acceptance.
REQ-023 RST also clears c_time_en_o in the cycle its strobe rises.
REQ-024 INIT and UPDT leave c_time_en_o unchanged.
REQ-025 START sets c_time_en_o to 1 in the next cycle; STOP clears it in the next cycle.
REQ-026 START and STOP go directly to GAP and skip HOLD.
REQ-027 NOP and illegal opcodes go directly to GAP with no output change except err_o for illegal opcodes; err_o pulses in the cycle after acceptance.
REQ-028 last_gnt_o updates in the cycle after every acceptance, including NOP and illegal opcodes.
REQ-029 Best-case throughput: one command per HOLD_CYC+GAP_CYC+1 cycles for strobe commands, and one per GAP_CYC+1 cycles for level, NOP and illegal commands.
REQ-030 Changing vld, op or dt while rdy is low has no effect.

Reset
REQ-031 While c_rst_ni is low at a clock edge: FSM goes to IDLE; all strobes, c_time_en_o, err_o, busy_o and both rdy outputs go to 0; c_offset_dt_o goes to 0; last_gnt_o goes to 1 (so the core wins the first tie).
REQ-032 Reset asserted mid-HOLD or mid-GAP aborts the command immediately; the first cycle after reset release is IDLE.

Verification
REQ-033 Core UPDT with dt=0x0000_0100, default parameters: core_rdy_o high in cycle N; c_time_updt_o high cycles N+1..N+4; c_offset_dt_o = 0x100 from N+1 onward; busy_o low and rdy available again at N+9.
REQ-034 Both requesters valid after reset, core START and host INIT dt=5: core granted first and c_time_en_o=1 at N+1; host granted at N+5; c_time_init_o high 4 cycles; c_time_en_o stays 1.
REQ-035 c_time_en_o=1, then host RST: c_time_rst_o and c_time_en_o=0 are both seen in the same cycle, N+1.
REQ-036 Core op=7: err_o pulses at N+1; no strobe; c_time_en_o and c_offset_dt_o unchanged; last_gnt_o=0.
REQ-037 Reset pulled low at the 2nd HOLD cycle of an INIT: the strobe is 0 in the next cycle and FSM is IDLE after release; a pending host vld is accepted in the first cycle after release.
REQ-038 Both requesters continuously valid for 6 commands: grants alternate core, host, core, and so on; no strobe overlap; every GAP is at least GAP_CYC cycles of all strobes low.
